// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem capture arbiter and its sample FIFO.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    localparam int unsigned SMP_W            = 15;
    localparam int unsigned SMP_PAD_W        = 17;
    localparam int unsigned DEF_RING_BASE    = 32'h0000_0F00;
    localparam int unsigned DEF_RING_DEPTH   = 256;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer state; one extra bit distinguishes full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dmem_capture_arbiter.sv
// Shares a single-port data RAM between the CPU and an accelerometer sample ring,
// CPU first, with a forced capture slot once the sample path has starved long enough.
module dmem_capture_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RING_BASE    = DEF_RING_BASE,
    parameter int unsigned RING_DEPTH   = DEF_RING_DEPTH,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_wren,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic                          cpu_stall,
    input  logic                          smp_valid,
    input  logic [SMP_W-1:0]              smp_data,
    output logic                          ram_wen,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic [$clog2(RING_DEPTH)-1:0] wr_ptr,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int unsigned PTR_W = $clog2(RING_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state;
    logic [STV_W-1:0] starve_cnt;
    logic [STV_W-1:0] starve_inc;
    logic [SMP_W-1:0] fifo_head;
    logic [LVL_W-1:0] fifo_level;
    logic [LVL_W-1:0] level_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             capture;
    logic             push;
    logic             drop;
    logic             blocked;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SMP_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (capture),
        .din   (smp_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // RAM grant: CPU wins unless a forced capture is due; reset silences the RAM port.
    always_comb begin
        cpu_stall = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = '0;
        capture   = 1'b0;
        if (!reset) begin
            capture = 1'b0;
        end else if (cpu_req && (state != FORCE)) begin
            ram_wen   = cpu_wren;
            ram_wdata = cpu_wdata;
        end else begin
            cpu_stall = cpu_req;
            if (!fifo_empty) begin
                capture   = 1'b1;
                ram_wen   = 1'b1;
                ram_addr  = ADDR_W'(RING_BASE) + ADDR_W'(wr_ptr);
                ram_wdata = DATA_W'(fifo_head);
            end
        end
    end

    assign push       = smp_valid && (!fifo_full || capture);
    assign drop       = smp_valid && fifo_full && !capture;
    assign level_nxt  = fifo_level + LVL_W'(push) - LVL_W'(capture);
    assign blocked    = (state == PEND) && cpu_req && !fifo_empty;
    assign starve_inc = (starve_cnt == STV_W'(STARVE_LIMIT)) ? starve_cnt
                                                             : starve_cnt + STV_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            starve_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + PTR_W'(1);

            // Sticky drop flag; a drop in the clearing cycle keeps it set.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            case (state)
                IDLE: begin
                    starve_cnt <= '0;
                    if (push) state <= PEND;
                end
                PEND: begin
                    if (capture)      starve_cnt <= '0;
                    else if (blocked) starve_cnt <= starve_inc;
                    if (level_nxt == '0) begin
                        state <= IDLE;
                    end else if (blocked && (starve_inc == STV_W'(STARVE_LIMIT))) begin
                        state <= FORCE;
                    end
                end
                FORCE: begin
                    starve_cnt <= '0;
                    state      <= (level_nxt != '0) ? PEND : IDLE;
                end
                default: begin
                    starve_cnt <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_capture_arbiter.sv
// Directed bench for dmem_capture_arbiter: hand-computed expectations checked with immediate assertions.
module tb_dmem_capture_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_wren;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        smp_valid;
    logic [14:0] smp_data;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [7:0]  wr_ptr;
    logic        overflow;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    dmem_capture_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_wren  (cpu_wren),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .wr_ptr    (wr_ptr),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_wren  = 1'b0;
        cpu_addr  = 12'h000;
        cpu_wdata = 32'h0;
        smp_valid = 1'b0;
        smp_data  = 15'h0;
        clr_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        settle();
    endtask

    task automatic chk_cap(input string tag, input logic [11:0] addr, input logic [31:0] data);
        chk({tag, "_wen"},  64'(ram_wen), 64'd1);
        chk({tag, "_addr"}, 64'(ram_addr), 64'(addr));
        chk({tag, "_data"}, 64'(ram_wdata), 64'(data));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        cpu_req  = 1'b1;
        cpu_wren = 1'b1;
        #3;
        chk("rst_wen",   64'(ram_wen),   64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_ptr",   64'(wr_ptr),    64'd0);
        chk("rst_ovf",   64'(overflow),  64'd0);
        do_reset();

        // Single sample, CPU idle: written the cycle after the push, not before.
        smp_valid = 1'b1; smp_data = 15'h1234;
        settle();
        chk("s1_nobypass", 64'(ram_wen), 64'd0);
        tick();
        smp_valid = 1'b0;
        settle();
        chk_cap("s1", 12'hF00, 32'h0000_1234);
        chk("s1_stall", 64'(cpu_stall), 64'd0);
        tick();
        settle();
        chk("s1_ptr", 64'(wr_ptr), 64'd1);
        chk("s1_wen_after", 64'(ram_wen), 64'd0);

        // Continuous CPU traffic starves one sample for 8 cycles, then a forced slot.
        do_reset();
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h010;
        smp_valid = 1'b1; smp_data = 15'h0AAA;
        settle();
        chk("s2_push_stall", 64'(cpu_stall), 64'd0);
        tick();
        smp_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("s2_blk_stall", 64'(cpu_stall), 64'd0);
            chk("s2_blk_addr",  64'(ram_addr),  64'h010);
            tick();
        end
        settle();
        chk("s2_force_stall", 64'(cpu_stall), 64'd1);
        chk_cap("s2_force", 12'hF00, 32'h0000_0AAA);
        tick();
        settle();
        chk("s2_after_stall", 64'(cpu_stall), 64'd0);
        chk("s2_after_wen",   64'(ram_wen),   64'd0);
        chk("s2_ptr",         64'(wr_ptr),    64'd1);

        // FIFO overflow under CPU traffic; clear loses to a same-cycle drop.
        do_reset();
        cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp_valid = 1'b1; smp_data = 15'(8'h11 + i);
            settle();
            chk("s3_ovf_pre", 64'(overflow), 64'd0);
            tick();
        end
        chk("s3_ovf_set", 64'(overflow), 64'd1);
        smp_data = 15'h16; clr_ovf = 1'b1;
        tick();
        chk("s3_ovf_setwins", 64'(overflow), 64'd1);
        smp_valid = 1'b0;
        tick();
        chk("s3_ovf_clr", 64'(overflow), 64'd0);
        clr_ovf = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_cap("s3_drain", 12'(12'hF00 + i), 32'(8'h11 + i));
            tick();
        end
        settle();
        chk("s3_empty_wen", 64'(ram_wen), 64'd0);
        chk("s3_ptr", 64'(wr_ptr), 64'd4);

        // 257 back-to-back samples wrap the ring pointer.
        do_reset();
        for (int i = 0; i <= 257; i++) begin
            smp_valid = (i < 257);
            smp_data  = 15'(i);
            settle();
            if (i > 0) chk_cap("s4_ring", 12'(12'hF00 + ((i - 1) % 256)), 32'(i - 1));
            tick();
        end
        smp_valid = 1'b0;
        settle();
        chk("s4_ptr", 64'(wr_ptr), 64'd1);
        chk("s4_idle_wen", 64'(ram_wen), 64'd0);

        // Reset with buffered samples discards them without any RAM write.
        do_reset();
        cpu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp_valid = 1'b1; smp_data = 15'(8'h40 + i);
            tick();
        end
        smp_valid = 1'b0; cpu_req = 1'b0;
        reset = 1'b0;
        settle();
        chk("s5_rst_wen", 64'(ram_wen), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_rst_hold_wen", 64'(ram_wen), 64'd0);
        end
        reset = 1'b1;
        settle();
        chk("s5_rel_wen", 64'(ram_wen), 64'd0);
        chk("s5_rel_ptr", 64'(wr_ptr), 64'd0);
        tick();
        chk("s5_still_empty", 64'(ram_wen), 64'd0);
        smp_valid = 1'b1; smp_data = 15'h77;
        tick();
        smp_valid = 1'b0;
        settle();
        chk_cap("s5_first", 12'hF00, 32'h0000_0077);

        // CPU write into the ring region between captures.
        do_reset();
        smp_valid = 1'b1; smp_data = 15'h0A1;
        tick();
        smp_data = 15'h0A2;
        settle();
        chk_cap("s6_cap1", 12'hF00, 32'h0000_00A1);
        tick();
        smp_valid = 1'b0;
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'hF05; cpu_wdata = 32'hDEAD_BEEF;
        settle();
        chk("s6_cpu_wen",   64'(ram_wen),   64'd1);
        chk("s6_cpu_addr",  64'(ram_addr),  64'hF05);
        chk("s6_cpu_data",  64'(ram_wdata), 64'hDEAD_BEEF);
        chk("s6_cpu_stall", 64'(cpu_stall), 64'd0);
        tick();
        cpu_req = 1'b0; cpu_wren = 1'b0;
        settle();
        chk_cap("s6_cap2", 12'hF01, 32'h0000_00A2);
        tick();
        settle();
        chk("s6_idle_wen", 64'(ram_wen), 64'd0);
        chk("s6_ptr", 64'(wr_ptr), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_capture_arbiter.md
DMEM_CAPTURE_ARBITER -- requirements
Module: dmem_capture_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, sets the RAM word-address width.
REQ-002 Parameter DATA_W, default 32, sets the RAM data width.
REQ-003 Parameter RING_BASE, default 12'hF00, is the first RAM address of the sample ring.
REQ-004 Parameter RING_DEPTH, default 256, is the ring length in words; it SHALL be a power of two and no more than 2^ADDR_W - RING_BASE.
REQ-005 Parameter FIFO_DEPTH, default 4, is the sample buffer depth; it SHALL be a power of two and at least 2.
REQ-006 Parameter STARVE_LIMIT, default 8, is the number of blocked cycles after which the capture path is forced.
REQ-007 Ports: clock, in, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 Ports: reset, in, 1 bit, asynchronous, active-low; 0 = in reset.
REQ-009 Ports: cpu_req in 1, cpu_wren in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W: the processor dmem access for the current cycle.
REQ-010 Ports: cpu_stall, out, 1 bit; 1 = the CPU access was not serviced this cycle and SHALL be held.
REQ-011 Ports: smp_valid in 1 (one-cycle strobe) and smp_data in 15: an accelerometer sample, already in the clock domain.
REQ-012 Ports: ram_wen out 1, ram_addr out ADDR_W, ram_wdata out DATA_W: drive the single-port RAM.
REQ-013 Ports: wr_ptr out log2(RING_DEPTH), overflow out 1, clr_ovf in 1.

Function
REQ-014 The block SHALL push smp_data into the FIFO in the cycle smp_valid=1 when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-015 When smp_valid=1, the FIFO is full and no pop occurs, the block SHALL drop the sample and set overflow.
REQ-016 overflow SHALL be sticky and cleared by clr_ovf=1; when set and clear occur in the same cycle, set SHALL win.
REQ-017 Grant is combinational; CPU has priority:
- cpu_req=1 and FSM not in FORCE: ram_* = cpu_wren / cpu_addr / cpu_wdata, cpu_stall=0.
- Otherwise, FIFO non-empty: capture write, ram_wen=1, ram_addr = RING_BASE + wr_ptr, ram_wdata = {17'b0, fifo head}, pop.
- Otherwise, idle: ram_wen=0, ram_addr=cpu_addr, ram_wdata=0.
REQ-018 On every capture write, wr_ptr SHALL increment by 1 and wrap from RING_DEPTH-1 to 0.
REQ-019 A sample pushed in cycle N SHALL be writable no earlier than cycle N+1; there is no same-cycle bypass.
REQ-020 The FSM SHALL have three states:
- IDLE: FIFO empty.
- PEND: FIFO non-empty.
- FORCE: a one-cycle forced capture.
REQ-021 FSM transitions:
- IDLE->PEND on a push.
- PEND->IDLE when the FIFO becomes empty.
- PEND->FORCE when starve_cnt reaches STARVE_LIMIT.
- FORCE->PEND if the FIFO stays non-empty after the pop, else FORCE->IDLE.
REQ-022 starve_cnt SHALL increment in PEND on each cycle cpu_req=1 blocks the pop, reset to 0 on any capture write, and saturate at STARVE_LIMIT.
REQ-023 In FORCE: capture write is performed, cpu_stall = cpu_req, starve_cnt cleared.
REQ-024 CPU accesses into the ring region SHALL NOT be blocked or checked.
REQ-025 The RAM read path is not routed through this block; reads take effect only in cycles where cpu_stall=0.

Reset
REQ-026 While reset=0:
- FIFO empty, FSM=IDLE.
- wr_ptr=0, starve_cnt=0, overflow=0.
- cpu_stall=0, ram_wen=0.
REQ-027 Assertion of reset mid-operation SHALL discard buffered samples without any RAM write.
REQ-028 After deassertion, the first capture write SHALL go to address RING_BASE.

Structure
REQ-029 Package dmem_arb_pkg SHALL hold:
- the FSM state enum (IDLE, PEND, FORCE);
- the sample pad width (17);
- the default RING_BASE, RING_DEPTH, FIFO_DEPTH and STARVE_LIMIT.
REQ-030 Sub-module sample_fifo SHALL be a synchronous FIFO, FIFO_DEPTH x 15, with push/pop/full/empty, simultaneous push+pop when full allowed, and the same clock/reset.
REQ-031 Target size is 150-300 lines of RTL including sample_fifo.

Verification
REQ-032 Scenario 1: reset released, smp_valid with 0x1234, cpu_req=0 -> next cycle ram_wen=1, ram_addr=0xF00, ram_wdata=0x00001234, then wr_ptr=1.
REQ-033 Scenario 2: cpu_req=1 continuously, one sample pushed -> 8 blocked cycles, then 1 cycle with cpu_stall=1 and a capture write to 0xF00, then cpu_stall=0.
REQ-034 Scenario 3: 5 samples on consecutive cycles while cpu_req=1 -> 4 buffered, 5th dropped, overflow=1; clr_ovf and a 6th drop in the same cycle -> overflow stays 1.
REQ-035 Scenario 4: 257 samples with cpu_req=0 -> last write at 0xF00, wr_ptr=1.
REQ-036 Scenario 5: reset=0 asserted with 3 samples buffered -> no further ram_wen; after release, FIFO empty and wr_ptr=0.
REQ-037 Scenario 6: CPU write to 0xF05 interleaved with captures -> CPU write serviced, cpu_stall=0, captures resume in idle cycles.
